// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: slot record, forward-select
// encoding and default HI/LO unit latencies.
package hazard_pkg;

    // Storage widths for slot fields; module AW/TW must not exceed these.
    localparam int unsigned MAX_AW = 8;
    localparam int unsigned MAX_TW = 4;

    localparam int unsigned FWD_NONE    = 0;
    localparam int unsigned DEF_MUL_CYC = 5;
    localparam int unsigned DEF_DIV_CYC = 10;

    typedef logic [MAX_AW-1:0] reg_addr_t;
    typedef logic [MAX_TW-1:0] tcnt_t;

    typedef struct packed {
        logic      valid;
        logic      regwrite;
        reg_addr_t rs;
        reg_addr_t rt;
        reg_addr_t wa;
        tcnt_t     tnew;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // Saturating decrement of a "cycles until result" count.
    function automatic tcnt_t tnew_dec(input tcnt_t t);
        return (t == '0) ? t : t - tcnt_t'(1);
    endfunction

    // A slot one stage older: same fields, result one cycle closer.
    function automatic slot_t slot_age(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = tnew_dec(s.tnew);
        return r;
    endfunction

    // True when the slot will write register r (r0 never counts).
    function automatic logic slot_hit(input slot_t s, input reg_addr_t r);
        return s.valid && s.regwrite && (s.wa != '0) && (s.wa == r);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// HI/LO unit busy counter: loads a latency on an accepted mult/div and counts down
// once per pipeline advance.
module md_busy_ctr #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: frozen without advance, load wins over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (advance) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks producers in EX..WB, raises stall for load-use and
// HI/LO-busy hazards, and selects forwarding sources for ID and EX operands.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned AW      = 5,
    parameter int unsigned NSTG    = 3,
    parameter int unsigned TW      = 3,
    parameter int unsigned MUL_CYC = DEF_MUL_CYC,
    parameter int unsigned DIV_CYC = DEF_DIV_CYC,
    localparam int unsigned FW     = $clog2(NSTG + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [TW-1:0] id_tuse_rs,
    input  logic [TW-1:0] id_tuse_rt,
    input  logic [AW-1:0] id_wa,
    input  logic          id_regwrite,
    input  logic [TW-1:0] id_tnew,
    input  logic          id_md_start,
    input  logic          id_md_is_div,
    input  logic          id_md_use,
    output logic          stall,
    output logic [FW-1:0] fwd_rs_d,
    output logic [FW-1:0] fwd_rt_d,
    output logic [FW-1:0] fwd_rs_e,
    output logic [FW-1:0] fwd_rt_e,
    output logic          md_busy
);

    localparam int unsigned MD_MAX = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int unsigned CW     = $clog2(MD_MAX + 1);

    // Index 0 is slot 1 (EX), index NSTG-1 is slot NSTG (WB).
    slot_t slot_q [NSTG];
    slot_t slot_d [NSTG];
    slot_t id_slot;

    logic          advance;
    logic          accept;
    logic          data_stall;
    logic          md_stall;
    logic [CW-1:0] md_load_val;

    assign advance = ~hold;
    assign md_stall = id_valid & id_md_use & md_busy;
    assign stall = hold | data_stall | md_stall;
    assign accept = id_valid & ~stall;
    assign md_load_val = id_md_is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);

    // Pack the ID instruction into a slot record for entry into EX.
    always_comb begin
        id_slot          = SLOT_BUBBLE;
        id_slot.valid    = 1'b1;
        id_slot.regwrite = id_regwrite;
        id_slot.rs       = reg_addr_t'(id_rs);
        id_slot.rt       = reg_addr_t'(id_rt);
        id_slot.wa       = reg_addr_t'(id_wa);
        id_slot.tnew     = tcnt_t'(id_tnew);
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign slot_d[k] = accept ? id_slot : SLOT_BUBBLE;
        end else begin : g_tail
            assign slot_d[k] = slot_age(slot_q[k-1]);
        end
    end

    // Slot pipeline: reset clears to bubbles, hold freezes, otherwise shift one stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                slot_q[k] <= SLOT_BUBBLE;
            end
        end else if (advance) begin
            slot_q <= slot_d;
        end
    end

    // ID hazard check and ID forward select; oldest-to-youngest so youngest match wins.
    always_comb begin
        data_stall = 1'b0;
        fwd_rs_d   = FW'(FWD_NONE);
        fwd_rt_d   = FW'(FWD_NONE);
        for (int k = int'(NSTG) - 1; k >= 0; k--) begin
            if (slot_hit(slot_q[k], reg_addr_t'(id_rs))) begin
                if (slot_q[k].tnew > tcnt_t'(id_tuse_rs)) begin
                    data_stall = 1'b1;
                end
                fwd_rs_d = (slot_q[k].tnew == '0) ? FW'(k + 1) : FW'(FWD_NONE);
            end
            if (slot_hit(slot_q[k], reg_addr_t'(id_rt))) begin
                if (slot_q[k].tnew > tcnt_t'(id_tuse_rt)) begin
                    data_stall = 1'b1;
                end
                fwd_rt_d = (slot_q[k].tnew == '0) ? FW'(k + 1) : FW'(FWD_NONE);
            end
        end
        data_stall = data_stall & id_valid;
    end

    // EX forward select: slot 1 sources against older slots, youngest match wins.
    always_comb begin
        fwd_rs_e = FW'(FWD_NONE);
        fwd_rt_e = FW'(FWD_NONE);
        for (int k = int'(NSTG) - 1; k >= 1; k--) begin
            if (slot_hit(slot_q[k], slot_q[0].rs)) begin
                fwd_rs_e = (slot_q[k].tnew == '0) ? FW'(k + 1) : FW'(FWD_NONE);
            end
            if (slot_hit(slot_q[k], slot_q[0].rt)) begin
                fwd_rt_e = (slot_q[k].tnew == '0) ? FW'(k + 1) : FW'(FWD_NONE);
            end
        end
        if (!slot_q[0].valid) begin
            fwd_rs_e = FW'(FWD_NONE);
            fwd_rt_e = FW'(FWD_NONE);
        end
    end

    md_busy_ctr #(
        .CW (CW)
    ) u_md_busy_ctr (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .load     (accept & id_md_start),
        .load_val (md_load_val),
        .busy     (md_busy)
    );

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width.
REQ-002 SHALL have parameter NSTG, default 3: tracked producer slots after ID (slot 1 = EX, slot NSTG = WB).
REQ-003 SHALL have parameter TW, default 3: Tuse/Tnew width.
REQ-004 SHALL have parameters MUL_CYC, default 5, and DIV_CYC, default 10: HI/LO busy cycles.
REQ-005 SHALL use derived width FW = clog2(NSTG+1) for forward selects.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port hold, input, 1: global freeze (memory wait).
REQ-009 SHALL have port id_valid, input, 1: ID holds a real instruction.
REQ-010 SHALL have ports id_rs and id_rt, input, AW each: ID source registers.
REQ-011 SHALL have ports id_tuse_rs and id_tuse_rt, input, TW each: cycles until ID needs rs/rt.
REQ-012 SHALL have ports id_wa (AW), id_regwrite (1) and id_tnew (TW, value at EX entry), all inputs.
REQ-013 SHALL have ports id_md_start (1), id_md_is_div (1) and id_md_use (1: reads/writes HI/LO or is an md op), all inputs.
REQ-014 SHALL have ports stall, output, 1: hold PC/IF/ID and bubble EX.
REQ-015 SHALL have ports fwd_rs_d and fwd_rt_d, output, FW each: ID operand source, 0 = regfile, k = slot k.
REQ-016 SHALL have ports fwd_rs_e and fwd_rt_e, output, FW each: EX operand source, 0 = none, k = slot k (k>=2).
REQ-017 SHALL have port md_busy, output, 1: HI/LO unit busy.

Function
REQ-018 SHALL hold per slot: valid, rs, rt, wa, regwrite and tnew.
REQ-019 Slot advance SHALL occur when hold=0: slot k+1 <= slot k with tnew decremented, saturating at 0.
REQ-020 On advance, slot 1 SHALL load the ID fields if id_valid && !stall, else a bubble (valid=0, regwrite=0).
REQ-021 When hold=1, all slots and the md counter SHALL be unchanged and stall=1.
REQ-022 A match SHALL mean: slot valid && regwrite && wa!=0 && wa == the register compared.
REQ-023 Data stall SHALL assert when id_valid and any slot matches id_rs with tnew > id_tuse_rs, or matches id_rt with tnew > id_tuse_rt.
REQ-024 MD stall SHALL assert when id_valid && id_md_use && md_busy.
REQ-025 stall SHALL be combinational: hold | data stall | MD stall.
REQ-026 fwd_*_d SHALL select the youngest (lowest k) matching slot if its tnew==0; if the youngest match has tnew>0, or there is no match, it SHALL be 0 (EX forwarding corrects later).
REQ-027 fwd_*_e SHALL compare slot 1 rs/rt against slots 2..NSTG, youngest match with tnew==0 wins, else 0.
REQ-028 Forwarding SHALL be 0 when slot 1 is a bubble.
REQ-029 The md counter SHALL load MUL_CYC, or DIV_CYC when id_md_is_div, on an advance that accepts an id_md_start instruction.
REQ-030 Otherwise the md counter SHALL decrement toward 0 on each advance.
REQ-031 md_busy SHALL equal counter != 0.
REQ-032 A start cannot coincide with busy, because md_use stalls it.

Reset
REQ-033 reset SHALL clear every slot to a bubble and the md counter to 0, with priority over hold.
REQ-034 After reset, stall = hold, md_busy=0 and all fwd outputs=0.
REQ-035 Reset mid-divide SHALL drop md_busy on the next cycle.

Structure
REQ-036 Package hazard_pkg SHALL hold the slot record typedef, the FWD_NONE=0 constant and the default MUL_CYC/DIV_CYC values.
REQ-037 Sub-module md_busy_ctr (load, decrement, busy) SHALL hold the HI/LO counter.
REQ-038 The slot array SHALL use a generate loop over NSTG.

Verification
REQ-039 lw r8 (tnew=2) accepted, then next ID add rs=8 tuse=1 -> stall=1 for 1 cycle; add then accepted, fwd_rs_d=0; next cycle fwd_rs_e=3.
REQ-040 addu r9 (tnew=1), then beq rs=9 tuse=0 -> stall 1 cycle, then fwd_rs_d=2, stall=0.
REQ-041 Producer wa=0 with tnew=2 and consumer rs=0 -> stall=0, all fwd=0.
REQ-042 mult (MUL_CYC=5) accepted, then mfhi (md_use) -> stall=1 for 5 cycles, md_busy falls, mfhi accepted; repeat with div -> 10 cycles.
REQ-043 hold=1 for 3 cycles during the lw->add stall -> slots frozen, stall=1; after release, behaviour matches REQ-039 shifted by 3.
REQ-044 reset pulsed 2 cycles into div -> md_busy=0 and fwd=0 the next cycle; mfhi proceeds without stall.
